// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock ratio meter.
package clk_meas_pkg;

    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_TIMEOUT  = (2 ** DEF_CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level, with a rising-edge pulse
// derived from the synchronized level and its previous sample.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous clock in clk cycles,
// tracks period stability for lock, and flags loss of the input.
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
    parameter int unsigned TOL         = 0,
    parameter int unsigned TIMEOUT     = (2 ** CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned DIFF_W  = CNT_W + 1;
    localparam int unsigned MATCH_W = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TO_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic [DIFF_W-1:0]  TOL_LIMIT = DIFF_W'(TOL);
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    meas_state_t        r_state,      w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
    logic [CNT_W-1:0]   r_hcnt,       w_hcnt_nxt;
    logic [CNT_W-1:0]   r_prev_per,   w_prev_per_nxt;
    logic               r_have_prev,  w_have_prev_nxt;
    logic [MATCH_W-1:0] r_match,      w_match_nxt;
    logic [CNT_W-1:0]   r_period,     w_period_nxt;
    logic [CNT_W-1:0]   r_high,       w_high_nxt;
    logic               r_meas_valid, w_meas_valid_nxt;
    logic               r_locked,     w_locked_nxt;
    logic               r_timeout,    w_timeout_nxt;

    logic               w_level;
    logic               w_rise;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_hcnt_inc;
    logic [DIFF_W-1:0]  w_diff;
    logic               w_in_tol;
    logic               w_timed_out;
    logic [MATCH_W-1:0] w_match_inc;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (sig_in),
        .o_level (w_level),
        .o_rise_c(w_rise)
    );

    // Saturating counters, and period difference widened so it cannot wrap
    assign w_cnt_inc   = (r_cnt  == CNT_MAX) ? r_cnt  : r_cnt  + CNT_ONE;
    assign w_hcnt_inc  = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_ONE;
    assign w_diff      = (r_cnt >= r_prev_per) ? ({1'b0, r_cnt} - {1'b0, r_prev_per})
                                               : ({1'b0, r_prev_per} - {1'b0, r_cnt});
    assign w_in_tol    = (w_diff <= TOL_LIMIT);
    assign w_timed_out = (r_cnt >= TO_LIMIT);
    assign w_match_inc = (r_match >= MATCH_TOP) ? MATCH_TOP : r_match + MATCH_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_prev_per   <= '0;
            r_have_prev  <= 1'b0;
            r_match      <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_prev_per   <= w_prev_per_nxt;
            r_have_prev  <= w_have_prev_nxt;
            r_match      <= w_match_nxt;
            r_period     <= w_period_nxt;
            r_high       <= w_high_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_locked     <= w_locked_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hcnt_nxt       = r_hcnt;
        w_prev_per_nxt   = r_prev_per;
        w_have_prev_nxt  = r_have_prev;
        w_match_nxt      = r_match;
        w_period_nxt     = r_period;
        w_high_nxt       = r_high;
        w_meas_valid_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_timeout_nxt    = r_timeout;

        if (!enable) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_hcnt_nxt      = '0;
            w_have_prev_nxt = 1'b0;
            w_match_nxt     = '0;
            w_locked_nxt    = 1'b0;
            w_timeout_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt       = '0;
                    w_hcnt_nxt      = '0;
                    w_have_prev_nxt = 1'b0;
                    w_match_nxt     = '0;
                    w_locked_nxt    = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_state_nxt     = ST_WAIT_EDGE;
                end
                ST_WAIT_EDGE: begin
                    if (w_rise) begin
                        w_cnt_nxt     = CNT_ONE;
                        w_hcnt_nxt    = CNT_ONE;
                        w_timeout_nxt = 1'b0;
                        w_state_nxt   = ST_MEASURE;
                    end else if (w_timed_out) begin
                        w_cnt_nxt       = '0;
                        w_timeout_nxt   = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_have_prev_nxt = 1'b0;
                        w_match_nxt     = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_MEASURE: begin
                    // A rise coinciding with the timeout threshold is still a measurement
                    if (w_rise) begin
                        w_period_nxt     = r_cnt;
                        w_high_nxt       = r_hcnt;
                        w_meas_valid_nxt = 1'b1;
                        w_cnt_nxt        = CNT_ONE;
                        w_hcnt_nxt       = CNT_ONE;
                        w_timeout_nxt    = 1'b0;
                        w_prev_per_nxt   = r_cnt;
                        w_have_prev_nxt  = 1'b1;
                        if (!r_have_prev) begin
                            w_match_nxt  = '0;
                            w_locked_nxt = 1'b0;
                        end else if (w_in_tol) begin
                            w_match_nxt  = w_match_inc;
                            w_locked_nxt = (w_match_inc == MATCH_TOP);
                        end else begin
                            w_match_nxt  = '0;
                            w_locked_nxt = 1'b0;
                        end
                    end else if (w_timed_out) begin
                        w_cnt_nxt       = '0;
                        w_timeout_nxt   = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_have_prev_nxt = 1'b0;
                        w_match_nxt     = '0;
                        w_state_nxt     = ST_WAIT_EDGE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_level) begin
                            w_hcnt_nxt = w_hcnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures an incoming divided or foreign clock against the system clock. It reports the period and high time of the incoming signal in `clk` cycles, and declares lock once the period is stable. It is the receiving end of the clock-divider path: it sits on the monitor/BIST side and recovers the effective division ratio from the divider's output, then flags loss of that clock. The sampled signal is asynchronous to `clk` and is synchronized internally.

## Interface
Parameters:
- `CNT_W`, 16: width of the period, high-time and timeout counters.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer, minimum 2.
- `LOCK_CNT`, 4: number of consecutive in-tolerance measurements required for lock, minimum 2.
- `TOL`, 0: allowed absolute difference in `clk` cycles between successive periods.
- `TIMEOUT`, 2**CNT_W-1: number of `clk` cycles without a rising edge that declares loss of the input.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  measurement enable; low forces IDLE.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `period`  out  CNT_W  last measured rising-to-rising interval, in `clk` cycles.
- `high_time`  out  CNT_W  `clk` cycles the synchronized input was high within that interval.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  period is stable.
- `timeout`  out  1  no rising edge for `TIMEOUT` cycles; this is a level output.

## Operation
- Reset: all outputs 0, all counters 0, state IDLE.
- Rising-edge detect (`rise`): the synchronized input is 1 and its previous sample is 0.
- States:
  - IDLE: counters cleared; `locked`=0; `timeout`=0. Goes to WAIT_EDGE when `enable`=1.
  - WAIT_EDGE: waits for the first `rise`. On `rise`: set `cnt`<=1, set `hcnt`<=1, go to MEASURE. No output is produced from this first edge.
  - MEASURE:
    - Each cycle without `rise`: `cnt`<=`cnt`+1, saturating at the maximum. `hcnt` increments when the synchronized input is 1.
    - On `rise`: `period`<=`cnt`; `high_time`<=`hcnt`; `meas_valid`<=1; `cnt`<=1; `hcnt`<=1.
- Timeout: in WAIT_EDGE or MEASURE, `cnt` reaching `TIMEOUT` without a `rise` does the following:
  - `timeout`<=1 and `locked`<=0.
  - Lock history is cleared and the block returns to WAIT_EDGE.
  - `timeout` stays high until the next `rise`.
- `enable` falling in any state: go to IDLE on the next clock. `period` and `high_time` hold their last values; `meas_valid` is not asserted.
- Lock:
  - After each measurement, compare |new − previous period| against `TOL`.
  - In tolerance: `match_cnt` increments, saturating at `LOCK_CNT`−1.
  - Out of tolerance: `match_cnt` goes to 0 and `locked`<=0 in the same update as `meas_valid`.
  - `locked`<=1 when `match_cnt` reaches `LOCK_CNT`−1, i.e. on the `LOCK_CNT`-th consecutive consistent measurement.
  - The first measurement after WAIT_EDGE has no predecessor and sets `match_cnt`=0.
- Arithmetic: counters are unsigned `CNT_W` bits. The difference is computed in `CNT_W`+1 bits to avoid wrap. A period that saturates is still reported and cannot match a non-saturated period when `TOL` < 1.
- Simultaneous `rise` and the `TIMEOUT` threshold in the same cycle: `rise` wins, the measurement is reported, and `timeout` is not set.

## Timing
- Input edge to `rise`: `SYNC_STAGES`+1 `clk` cycles.
- `rise` to `meas_valid`, `period` and `high_time` visible: 1 cycle, registered.
- For a clean square wave of period P cycles, successive `meas_valid` pulses are P cycles apart. The minimum measurable P is 2.
- `locked` and `timeout` update in the same cycle as the corresponding `meas_valid`, or on the timeout edge.
- `enable` low to IDLE: 1 cycle.

## Structure
- Package `clk_meas_pkg`: state enum (IDLE, WAIT_EDGE, MEASURE) and the default constants for `CNT_W`, `LOCK_CNT` and `TIMEOUT`.
- Sub-module `sync_edge_det`: `SYNC_STAGES` synchronizer plus a previous-sample register. Outputs the synchronized level and a `rise` pulse. It is reusable elsewhere.
- Top level: FSM, period/high counters, lock tracker, output registers.

## Test plan
- Square wave, period 10, high 5, from `enable`=1: the first `meas_valid` follows the second input edge with `period`=10 and `high_time`=5. `locked` rises on the 4th `meas_valid` with `LOCK_CNT`=4 and `TOL`=0.
- Locked at period 10, then one period of 12: `locked` drops with that `meas_valid`. It reasserts after 4 further measurements of 10 each.
- `TOL`=1 with periods alternating 9/10: lock is achieved. With `TOL`=0: never locked.
- Input stops high with `TIMEOUT`=50: `timeout`=1 and `locked`=0 exactly 50 cycles after the last `rise`. On resume, `timeout` clears at the first `rise`, and the first `meas_valid` comes one period later.
- `enable` dropped mid-measurement, and separately `rst_n` asserted mid-period: with `enable` low, `period`/`high_time` hold, `locked` goes to 0 and no `meas_valid` occurs; with `rst_n`, all outputs are 0 immediately. Re-enable: WAIT_EDGE, no spurious `meas_valid`.
- Minimum period 2 (toggling every cycle): `period`=2 and `high_time`=1 on every `meas_valid`. Also a `TIMEOUT`-coincident edge: the measurement is reported and `timeout` stays 0.
